// File: rtl/bus_xfer_engine.sv
// rtl/bus_xfer_engine.sv - round-robin register-transfer engine with a two-stage bus pipeline
// Optional build macro XFER_R0_ZERO_EN makes register 0 a hard zero.
module bus_xfer_engine #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int NCH    = 2,
    localparam int IDX_W = $clog2(NREGS + 2)
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   hold,
    input  logic [NCH-1:0]         ch_req,
    input  logic [NCH*IDX_W-1:0]   ch_src,
    input  logic [NCH*IDX_W-1:0]   ch_dst,
    output logic [NCH-1:0]         ch_ack,
    input  logic [DATA_W-1:0]      ext_in,
    output logic [DATA_W-1:0]      out_q,
    output logic [DATA_W-1:0]      bus_q,
    output logic                   bus_valid,
    output logic                   err,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [DATA_W-1:0]      rd_data
);

    localparam int AW    = $clog2(NREGS);
    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] PORT_IDX = IDX_W'(NREGS);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [PTR_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  s2_dst_q;
    logic              s2_ill_q;
    logic              valid_q;
    logic              err_q;

    logic              gnt;
    logic [PTR_W-1:0]  gnt_ch;
    logic [IDX_W-1:0]  sel_src, sel_dst;
    logic              illegal;
    logic [DATA_W-1:0] src_data;
    logic              wr_reg, wr_out;

    // Scan channels in rotated order rr_q, rr_q+1, ... and take the first requester.
    always_comb begin
        gnt     = 1'b0;
        gnt_ch  = '0;
        ch_ack  = '0;
        sel_src = '0;
        sel_dst = '0;
        for (int i = 0; i < NCH; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!clr && !hold && !gnt && ch_req[c] &&
                    ((int'(rr_q) + i == c) || (int'(rr_q) + i - NCH == c))) begin
                    gnt       = 1'b1;
                    gnt_ch    = PTR_W'(c);
                    ch_ack[c] = 1'b1;
                    sel_src   = ch_src[c*IDX_W +: IDX_W];
                    sel_dst   = ch_dst[c*IDX_W +: IDX_W];
                end
            end
        end
        rr_d = rr_q;
        if (gnt) begin
            rr_d = (gnt_ch == PTR_W'(NCH - 1)) ? '0 : gnt_ch + PTR_W'(1);
        end
    end

    always_comb begin
        illegal  = (sel_src > PORT_IDX) || (sel_dst > PORT_IDX);
        src_data = '0;
        if (sel_src < PORT_IDX) begin
            // An illegal stage-2 move carries no write, so it must never be forwarded.
            if (valid_q && !s2_ill_q && (s2_dst_q == sel_src)) begin
                src_data = bus_q;
            end else begin
                src_data = regs_q[sel_src[AW-1:0]];
            end
`ifdef XFER_R0_ZERO_EN
            if (sel_src == '0) begin
                src_data = '0;
            end
`endif
        end else if (sel_src == PORT_IDX) begin
            src_data = ext_in;
        end
    end

    always_comb begin
        wr_reg = valid_q && !s2_ill_q && (s2_dst_q < PORT_IDX);
        wr_out = valid_q && !s2_ill_q && (s2_dst_q == PORT_IDX);
`ifdef XFER_R0_ZERO_EN
        if (s2_dst_q == '0) begin
            wr_reg = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rr_q     <= '0;
            out_q    <= '0;
            bus_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            s2_dst_q <= '0;
            s2_ill_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            rr_q    <= rr_d;
            valid_q <= gnt;
            err_q   <= gnt && illegal;
            if (gnt) begin
                bus_q    <= illegal ? '0 : src_data;
                s2_dst_q <= sel_dst;
                s2_ill_q <= illegal;
            end
            if (wr_reg) begin
                regs_q[s2_dst_q[AW-1:0]] <= bus_q;
            end
            if (wr_out) begin
                out_q <= bus_q;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_idx < PORT_IDX) begin
            rd_data = regs_q[rd_idx[AW-1:0]];
`ifdef XFER_R0_ZERO_EN
            if (rd_idx == '0) begin
                rd_data = '0;
            end
`endif
        end else if (rd_idx == PORT_IDX) begin
            rd_data = out_q;
        end
    end

    assign bus_valid = valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bus_xfer_engine.sv
// tb/tb_bus_xfer_engine.sv - directed-vector bench for bus_xfer_engine
module tb_bus_xfer_engine;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int NC = 2;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          clr;
    logic          hold;
    logic [NC-1:0] ch_req;
    logic [NC*IW-1:0] ch_src;
    logic [NC*IW-1:0] ch_dst;
    logic [NC-1:0] ch_ack;
    logic [DW-1:0] ext_in;
    logic [DW-1:0] out_q;
    logic [DW-1:0] bus_q;
    logic          bus_valid;
    logic          err;
    logic [IW-1:0] rd_idx;
    logic [DW-1:0] rd_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_xfer_engine #(.DATA_W(DW), .NREGS(NR), .NCH(NC)) dut (
        .clk       (clk),
        .clr       (clr),
        .hold      (hold),
        .ch_req    (ch_req),
        .ch_src    (ch_src),
        .ch_dst    (ch_dst),
        .ch_ack    (ch_ack),
        .ext_in    (ext_in),
        .out_q     (out_q),
        .bus_q     (bus_q),
        .bus_valid (bus_valid),
        .err       (err),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        rd_idx = idx;
        #1;
        chk(tag, rd_data, exp);
    endtask

    // Single-channel move: present, check the grant, let the edge accept it.
    task automatic mv(input int ch, input logic [4:0] s, input logic [4:0] d);
        ch_req = NC'(1 << ch);
        ch_src[ch*IW +: IW] = s;
        ch_dst[ch*IW +: IW] = d;
        #1;
        chk("mv_ack", 32'(ch_ack), 32'(1 << ch));
        @(posedge clk);
        #1;
        ch_req = '0;
    endtask

    initial begin
        clr = 1'b1; hold = 1'b0; ch_req = '0; ch_src = '0; ch_dst = '0;
        ext_in = '0; rd_idx = '0;
        tick(); tick();
        clr = 1'b0;
        chk("rst_valid", 32'(bus_valid), 32'd0);
        chk("rst_err",   32'(err),       32'd0);
        chk("rst_busq",  bus_q,          32'd0);
        chk("rst_outq",  out_q,          32'd0);

        ext_in = 32'h55;
        mv(0, 5'd16, 5'd3);
        tick();
        rd("r3_loaded", 5'd3, 32'h55);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        rd("r3_after_clr", 5'd3, 32'd0);
        chk("clr_busq",  bus_q,          32'd0);
        chk("clr_valid", 32'(bus_valid), 32'd0);
        chk("clr_outq",  out_q,          32'd0);

        ext_in = 32'h11;
        ch_src = {5'd16, 5'd16};
        ch_dst = {5'd7, 5'd6};
        ch_req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("fair_ack", 32'(ch_ack), (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
        end
        ch_req = '0;

        ext_in = 32'hDEADBEEF;
        mv(0, 5'd16, 5'd1);
        chk("dep_busq_t1",  bus_q,          32'hDEADBEEF);
        chk("dep_valid_t1", 32'(bus_valid), 32'd1);
        mv(0, 5'd1, 5'd2);
        chk("dep_busq_fwd", bus_q, 32'hDEADBEEF);
        rd("dep_r1", 5'd1, 32'hDEADBEEF);
        tick();
        rd("dep_r2", 5'd2, 32'hDEADBEEF);

        mv(0, 5'd16, 5'd17);
        chk("ill_err",   32'(err),       32'd1);
        chk("ill_valid", 32'(bus_valid), 32'd1);
        chk("ill_busq",  bus_q,          32'd0);
        tick();
        chk("ill_err_drop",   32'(err),       32'd0);
        chk("ill_valid_drop", 32'(bus_valid), 32'd0);
        rd("ill_r1",    5'd1,  32'hDEADBEEF);
        rd("ill_out",   5'd16, 32'd0);
        rd("ill_rd17",  5'd17, 32'd0);
        mv(0, 5'd18, 5'd2);
        chk("ill_src_err",  32'(err), 32'd1);
        chk("ill_src_busq", bus_q,    32'd0);
        tick();
        rd("ill_src_r2", 5'd2, 32'hDEADBEEF);

        ch_src = {5'd16, 5'd16};
        ch_dst = {5'd7, 5'd6};
        hold = 1'b1;
        ch_req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ack", 32'(ch_ack), 32'd0);
            tick();
        end
        hold = 1'b0;
        #1;
        chk("post_hold_ack", 32'(ch_ack), 32'd2);
        tick();
        ch_req = '0;

        ext_in = 32'h77;
        mv(0, 5'd16, 5'd8);
        hold = 1'b1;
        #1;
        chk("hold_s2_valid", 32'(bus_valid), 32'd1);
        tick();
        chk("hold_s2_drop", 32'(bus_valid), 32'd0);
        rd("hold_s2_r8", 5'd8, 32'h77);
        hold = 1'b0;

        ext_in = 32'h1234;
        mv(0, 5'd16, 5'd5);
        mv(0, 5'd5, 5'd16);
        chk("outq_t1", out_q, 32'd0);
        tick();
        chk("outq_t2", out_q, 32'h1234);
        rd("rd_out", 5'd16, 32'h1234);

        ext_in = 32'hABCD;
        mv(0, 5'd16, 5'd9);
        clr = 1'b1;
        ch_req = 2'b01;
        #1;
        chk("clr_ack", 32'(ch_ack), 32'd0);
        tick();
        clr = 1'b0;
        ch_req = '0;
        rd("clr_r9_discard", 5'd9, 32'd0);
        rd("clr_r5",         5'd5, 32'd0);

        ext_in = 32'hFF;
        mv(0, 5'd16, 5'd0);
        mv(0, 5'd0, 5'd4);
        chk("r0_err", 32'(err), 32'd0);
        tick();
`ifdef XFER_R0_ZERO_EN
        rd("r0_r4", 5'd4, 32'd0);
        rd("r0_r0", 5'd0, 32'd0);
`else
        rd("r0_r4", 5'd4, 32'hFF);
        rd("r0_r0", 5'd0, 32'hFF);
`endif
        chk("r0_err_after", 32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_xfer_engine.md
# bus_xfer_engine

Parametrised register-transfer engine for the processor datapath. It holds a bank of general registers, one input port and one output port, and executes register-to-register moves over a single shared internal bus. Several requesting channels (control sequencer, debug/DMA) issue moves, and a round-robin arbiter serves them at one move per cycle. A two-stage pipeline with write-to-read forwarding lets back-to-back dependent moves complete correctly.

## Interface
- DATA_W, 32, register and bus width
- NREGS, 16, number of general registers (≥2)
- NCH, 2, number of requesting channels (≥1)
- IDX_W, $clog2(NREGS+2), index width (derived localparam)

- clk  in  1  clock; all state updates on rising edge
- clr  in  1  reset, synchronous, active-high
- hold  in  1  when high, no new grants; a move already in stage 2 still completes
- ch_req  in  NCH  per-channel move request
- ch_src  in  NCH*IDX_W  per-channel source index, channel c at [c*IDX_W +: IDX_W]
- ch_dst  in  NCH*IDX_W  per-channel destination index, same packing
- ch_ack  out  NCH  one-hot grant, combinational (Mealy), same cycle as acceptance
- ext_in  in  DATA_W  input-port data, source index NREGS
- out_q  out  DATA_W  output-port register, destination index NREGS
- bus_q  out  DATA_W  registered bus value of the move in stage 2
- bus_valid  out  1  stage 2 holds a valid move
- err  out  1  one-cycle pulse, registered: an accepted move had an illegal index
- rd_idx  in  IDX_W  debug read index
- rd_data  out  DATA_W  combinational debug read

## Operation
- Index map:
  - 0..NREGS-1 selects a general register.
  - Source NREGS selects ext_in.
  - Destination NREGS selects out_q.
  - Index > NREGS is illegal.
- Arbitration:
  - rr_ptr is in 0..NCH-1.
  - When not hold and not clr, the engine grants the first c with ch_req[c]=1, scanning rr_ptr, rr_ptr+1, … modulo NCH.
  - ch_ack[c]=1 in that cycle. After a grant, rr_ptr <= c+1 mod NCH.
  - With no grant, rr_ptr is unchanged.
- Handshake:
  - A requester holds req/src/dst stable until it sees ack.
  - On the cycle after ack, it either drops req or presents a new move.
- Stage 1 (grant cycle): bus_q <= source data, s2_dst <= dst, bus_valid <= 1.
- Stage 2 (next cycle): the destination register is written with bus_q at the end of that cycle.
- Forwarding: if stage 2 is valid and s2_dst equals the stage-1 source index (legal register or NREGS is not a source, so registers only), stage 1 takes bus_q instead of the array.
- Illegal move:
  - Still acked and enters stage 2 with bus_valid=1 and bus_q=0.
  - Performs no write; err pulses in stage 2.
- Source = destination is legal and rewrites the same value.
- rd_data:
  - Reads the array, or out_q at NREGS; 0 for illegal indices.
  - No forwarding, so a stage-2 write is not visible on rd_data until the following cycle.

## Timing
- Reset (clr high at edge): all registers, out_q, bus_q = 0; bus_valid=0, err=0, rr_ptr=0.
- ch_ack=0 whenever clr or hold is high.
- Reset during an in-flight move: the stage-2 write in that cycle is discarded.
- Latency: grant at cycle t → bus_q/bus_valid at t+1 → destination readable at t+2. Throughput is one move per cycle.
- Simultaneous requests: exactly one ack per cycle, never more.
- hold asserted with stage 2 valid: that write completes and bus_valid falls the following cycle.

## Configuration
- XFER_R0_ZERO_EN defined:
  - Register 0 reads as 0 everywhere: source, forwarding path, rd_data.
  - Writes to it are discarded; no err is raised.
- XFER_R0_ZERO_EN undefined: register 0 is an ordinary register.

## Test plan
- Reset: load R3=0x55 via ext_in, assert clr one cycle → all outputs 0, rd_idx=3 gives 0, bus_valid=0.
- Dependent pair: ext_in=0xDEADBEEF, ch0 moves NREGS→R1 at t, then R1→R2 at t+1 → bus_q=0xDEADBEEF at t+1 and t+2; R2=0xDEADBEEF readable at t+3.
- Fairness: NCH=2, both channels hold req continuously for 6 cycles → ack sequence ch0,ch1,ch0,ch1,ch0,ch1.
- Illegal/hold: ch0 dst=NREGS+1 → ack, err pulse one cycle later, no register changes. hold=1 with req high for 3 cycles → no ack, rr_ptr unchanged.
- Output port: move R5 (0x1234) → dst NREGS → out_q=0x1234 two cycles after grant.
- Macro: with XFER_R0_ZERO_EN, move ext_in=0xFF→R0 then R0→R4 → R4=0, err=0. Without the macro, R4=0xFF.
